vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_WIDTH, default 12: bit width of horizontal counter and x_o.
REQ-002 Parameter V_WIDTH, default 11: bit width of vertical counter and y_o.
REQ-003 Parameter PIPE_DELAY, default 0, range 0..7: extra register stages on all timing outputs.
REQ-004 Parameter DEF_H_LINE (line_t), default '{640,16,96,48,PulseActiveLow}: horizontal timing after reset.
REQ-005 Parameter DEF_V_LINE (line_t), default '{480,10,2,33,PulseActiveLow}: vertical timing after reset.
REQ-006 clk_i  in  1  pixel clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 enable_i  in  1  clock enable for counters and output pipeline.
REQ-008 h_line_i, v_line_i  in  line_t  requested timing (active, fp, sync, bp, polarity).
REQ-009 cfg_valid_i  in  1  request to load h_line_i/v_line_i; cfg_ready_o  out  1  request accepted when high with cfg_valid_i.
REQ-010 hde_o, vde_o, de_o (hde&vde)  out  1 each  data enables.
REQ-011 hsyn_o, vsyn_o  out  1 each  sync pulses with polarity applied.
REQ-012 eol_o, eof_o, sof_o  out  1 each  single-cycle pulses: last pixel of line, last pixel of frame, first pixel of frame.
REQ-013 x_o  out  H_WIDTH  horizontal position; y_o  out  V_WIDTH  vertical position.

Function
REQ-014 Horizontal counter hc SHALL run 0..Htot-1, Htot=active+fp+sync+bp; regions in order active [0,active), fp, sync, bp.
REQ-015 Vertical counter vc SHALL increment when hc wraps to 0 and itself wrap at Vtot-1 with identical region order.
REQ-016 Counters SHALL advance only when enable_i=1; with enable_i=0 all state and outputs hold.
REQ-017 x_o=hc, y_o=vc, undriven by region (valid whenever de_o=1).
REQ-018 Sync output SHALL be 0 in the sync region and 1 elsewhere for PulseActiveLow; inverted for PulseActiveHigh.
REQ-019 eol_o=1 when hc=Htot-1; eof_o=1 when hc=Htot-1 and vc=Vtot-1; sof_o=1 when hc=0 and vc=0.
REQ-020 All outputs SHALL be registered; latency from counter state to outputs is 1+PIPE_DELAY enabled cycles, all outputs mutually aligned.
REQ-021 Active timing lives in shadow registers; h_line_i/v_line_i SHALL never affect timing directly.
REQ-022 Handshake: cfg_valid_i&cfg_ready_o copies inputs into a pending register and drops cfg_ready_o.
REQ-023 Pending config SHALL be transferred to shadow on the enabled cycle where counters wrap from (Htot-1,Vtot-1) to (0,0); cfg_ready_o rises the following cycle.
REQ-024 A request arriving on the same cycle as the frame wrap SHALL be applied at the next frame wrap, not the current one.
REQ-025 Config with any field 0 (active, sync) or total exceeding 2**H_WIDTH / 2**V_WIDTH SHALL be accepted but discarded; shadow unchanged.
REQ-026 Counter widths SHALL not overflow: totals compared exactly, no modular wrap beyond Htot-1/Vtot-1.

Reset
REQ-027 On rst_ni=0 asynchronously: hc=vc=0, shadow=DEF_H_LINE/DEF_V_LINE, pending empty, cfg_ready_o=1, pipeline cleared.
REQ-028 Reset output values: hde_o=vde_o=de_o=0, eol_o=eof_o=sof_o=0, x_o=y_o=0, hsyn_o/vsyn_o at inactive level per default polarity.
REQ-029 Reset mid-frame or with a pending config SHALL discard the pending config; first sof_o appears 1+PIPE_DELAY enabled cycles after release.

Configuration
REQ-030 Macro VGA_TIMING_GEN_FRAME_CNT_EN: when defined, adds output frame_cnt_o (16 bit), reset 0, incremented on each frame wrap, aligned with sof_o, wraps at 65535->0; when undefined the port and counter do not exist and behaviour is otherwise identical.

Verification
REQ-031 Reset release, h='{4,1,2,1} v='{3,1,1,1} loaded via cfg then frame wrap -> frame 48 cycles, hsyn_o low at hc=5..6, eol_o every 8 cycles, one eof_o per frame.
REQ-032 Default 640x480 after reset, PIPE_DELAY=0 -> sof_o period 420000 cycles, de_o high 307200 cycles per frame.
REQ-033 cfg_valid_i asserted mid-frame -> cfg_ready_o low until wrap, new timing starts exactly at next sof_o, current frame unchanged.
REQ-034 enable_i toggled 1010... -> frame length doubles in clk_i cycles, x_o/y_o sequence identical to enable_i=1.
REQ-035 PIPE_DELAY=3 -> all outputs shifted by exactly 3 cycles vs PIPE_DELAY=0 run, mutually aligned.
REQ-036 rst_ni pulsed mid-frame with config pending -> outputs at reset values immediately, defaults used, pending discarded, frame_cnt_o=0 if macro defined.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA timing generator with shadowed config; define VGA_TIMING_GEN_FRAME_CNT_EN to add frame_cnt_o
package vga_timing_pkg;
  typedef enum logic {PulseActiveLow, PulseActiveHigh} polarity_e;
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
    polarity_e   pol;
  } line_t;
endpackage

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int    H_WIDTH    = 12,
  parameter int    V_WIDTH    = 11,
  parameter int    PIPE_DELAY = 0,
  parameter line_t DEF_H_LINE = '{16'd640, 16'd16, 16'd96, 16'd48, PulseActiveLow},
  parameter line_t DEF_V_LINE = '{16'd480, 16'd10, 16'd2, 16'd33, PulseActiveLow}
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  line_t              h_line_i,
  input  line_t              v_line_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  output logic               hde_o,
  output logic               vde_o,
  output logic               de_o,
  output logic               hsyn_o,
  output logic               vsyn_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic               sof_o,
  output logic [H_WIDTH-1:0] x_o,
  output logic [V_WIDTH-1:0] y_o
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt_o
`endif
);
  typedef struct packed {
    logic hde, vde, de, hsyn, vsyn, eol, eof, sof;
    logic [H_WIDTH-1:0] x;
    logic [V_WIDTH-1:0] y;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] fcnt;
`endif
  } out_t;

  function automatic logic [31:0] total(line_t l);
    return 32'(l.active) + 32'(l.fp) + 32'(l.sync) + 32'(l.bp);
  endfunction

  function automatic logic fits(line_t l, int w);
    return l.active != '0 && l.sync != '0 && total(l) <= (32'd1 << w);
  endfunction

  function automatic logic syn_level(logic [31:0] c, line_t l);
    logic [31:0] s;
    s = 32'(l.active) + 32'(l.fp);
    return (c >= s && c < s + 32'(l.sync)) ^ (l.pol == PulseActiveLow);
  endfunction

  function automatic out_t idle();
    out_t o;
    o = '0;
    o.hsyn = DEF_H_LINE.pol == PulseActiveLow;
    o.vsyn = DEF_V_LINE.pol == PulseActiveLow;
    return o;
  endfunction

  line_t sh_h, sh_v, pend_h, pend_v;
  logic [H_WIDTH-1:0] hc;
  logic [V_WIDTH-1:0] vc;
  logic [31:0] hcw, vcw;
  logic h_end, v_end, wrap, pend_ok;
  out_t nxt;
  out_t pipe [0:PIPE_DELAY];

  assign hcw     = 32'(hc);
  assign vcw     = 32'(vc);
  assign h_end   = hcw == total(sh_h) - 32'd1;
  assign v_end   = vcw == total(sh_v) - 32'd1;
  assign wrap    = enable_i && h_end && v_end;
  assign pend_ok = fits(pend_h, H_WIDTH) && fits(pend_v, V_WIDTH);

  // Pixel and line counters; wrap exactly at the programmed totals
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      hc <= '0;
      vc <= '0;
    end else if (enable_i) begin
      hc <= h_end ? '0 : hc + 1'b1;
      vc <= !h_end ? vc : v_end ? '0 : vc + 1'b1;
    end

  // One-deep pending slot, committed to the shadow only on the frame wrap; bad configs are dropped there
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sh_h        <= DEF_H_LINE;
      sh_v        <= DEF_V_LINE;
      pend_h      <= '0;
      pend_v      <= '0;
      cfg_ready_o <= 1'b1;
    end else if (wrap && !cfg_ready_o) begin
      cfg_ready_o <= 1'b1;
      if (pend_ok) begin
        sh_h <= pend_h;
        sh_v <= pend_v;
      end
    end else if (cfg_valid_i && cfg_ready_o) begin
      pend_h      <= h_line_i;
      pend_v      <= v_line_i;
      cfg_ready_o <= 1'b0;
    end

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] fc;

  // Frame counter steps on the wrap so the value travels with the following sof
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) fc <= '0;
    else if (wrap) fc <= fc + 1'b1;
`endif

  // Decode the current counter position into the output word
  always_comb begin
    nxt      = '0;
    nxt.hde  = hcw < 32'(sh_h.active);
    nxt.vde  = vcw < 32'(sh_v.active);
    nxt.de   = nxt.hde && nxt.vde;
    nxt.hsyn = syn_level(hcw, sh_h);
    nxt.vsyn = syn_level(vcw, sh_v);
    nxt.eol  = h_end;
    nxt.eof  = h_end && v_end;
    nxt.sof  = hc == '0 && vc == '0;
    nxt.x    = hc;
    nxt.y    = vc;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    nxt.fcnt = fc;
`endif
  end

  // Stage 0 registers the decode; later stages are a plain delay line, all gated by enable
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i <= PIPE_DELAY; i++) pipe[i] <= idle();
    end else if (enable_i) begin
      pipe[0] <= nxt;
      for (int i = 1; i <= PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
    end

  assign hde_o  = pipe[PIPE_DELAY].hde;
  assign vde_o  = pipe[PIPE_DELAY].vde;
  assign de_o   = pipe[PIPE_DELAY].de;
  assign hsyn_o = pipe[PIPE_DELAY].hsyn;
  assign vsyn_o = pipe[PIPE_DELAY].vsyn;
  assign eol_o  = pipe[PIPE_DELAY].eol;
  assign eof_o  = pipe[PIPE_DELAY].eof;
  assign sof_o  = pipe[PIPE_DELAY].sof;
  assign x_o    = pipe[PIPE_DELAY].x;
  assign y_o    = pipe[PIPE_DELAY].y;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  assign frame_cnt_o = pipe[PIPE_DELAY].fcnt;
`endif
endmodule
